class_argmax_sequencer: RTL

- Sequencing controller for the class-sum datapath of the Tsetlin machine inference path.
- On `start`, walks `class_sel` from 0 to NUM_CLASSES-1 and requests one class sum per class. Waits for each sum with a valid handshake and keeps a running signed argmax.
- Publishes `predicted_class` and `best_sum` together with a one-cycle `done`.
- Sits between the top-level inference control and the clause/vote accumulator.

---
 rtl/class_argmax_sequencer_if.sv | 39 +++
 rtl/class_argmax_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/class_argmax_sequencer_if.sv
// Bus between the class argmax sequencer (master) and its environment (slave):
// inference control plus the class-sum datapath. ARGMAX_TIMEOUT_EN adds timeout_err.
interface class_argmax_sequencer_if #(
  parameter int CLASS_W = 4,
  parameter int SUM_W   = 32
);
  logic                      start;
  logic                      busy;
  logic [CLASS_W-1:0]        class_sel;
  logic                      sum_req;
  logic signed [SUM_W-1:0]   class_sum;
  logic                      sum_valid;
  logic [CLASS_W-1:0]        predicted_class;
  logic signed [SUM_W-1:0]   best_sum;
  logic                      done;
`ifdef ARGMAX_TIMEOUT_EN
  logic                      timeout_err;

  modport master (
    input  start, class_sum, sum_valid,
    output busy, class_sel, sum_req, predicted_class, best_sum, done, timeout_err
  );

  modport slave (
    output start, class_sum, sum_valid,
    input  busy, class_sel, sum_req, predicted_class, best_sum, done, timeout_err
  );
`else
  modport master (
    input  start, class_sum, sum_valid,
    output busy, class_sel, sum_req, predicted_class, best_sum, done
  );

  modport slave (
    output start, class_sum, sum_valid,
    input  busy, class_sel, sum_req, predicted_class, best_sum, done
  );
`endif
endinterface

// File: rtl/class_argmax_sequencer.sv
// Scans all classes, requests one signed class sum each and keeps a running argmax.
// Optional WAIT watchdog with sticky timeout_err is enabled by defining ARGMAX_TIMEOUT_EN.
module class_argmax_sequencer #(
  parameter int NUM_CLASSES    = 10,
  parameter int CLASS_W        = 4,
  parameter int SUM_W          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                       clock,
  input logic                       reset,
  class_argmax_sequencer_if.master  bus
);

  localparam logic [CLASS_W-1:0]      LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);
  localparam logic [CLASS_W-1:0]      CLASS_ZERO = {CLASS_W{1'b0}};
  localparam logic [CLASS_W-1:0]      CLASS_ONE  = CLASS_W'(1);
  localparam logic signed [SUM_W-1:0] MOST_NEG   = {1'b1, {(SUM_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] SUM_ZERO   = {SUM_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Elaboration-time guard on the configuration range
  if ((NUM_CLASSES < 2) || (NUM_CLASSES > (2 ** CLASS_W)) || (TIMEOUT_CYCLES < 1)) begin : g_cfg_err
    $error("class_argmax_sequencer: illegal NUM_CLASSES/CLASS_W/TIMEOUT_CYCLES");
  end

  // The first class always loads; later classes need a strictly larger sum so ties keep the lower index
  function automatic logic take_new(input logic signed [SUM_W-1:0] cand,
                                    input logic signed [SUM_W-1:0] cur,
                                    input logic [CLASS_W-1:0]      sel);
    take_new = (sel == CLASS_ZERO) || (cand > cur);
  endfunction

  state_t                   state_r, state_s;
  logic [CLASS_W-1:0]       class_sel_r, class_sel_s;
  logic                     sum_req_r, sum_req_s;
  logic                     busy_r, busy_s;
  logic                     done_r, done_s;
  logic [CLASS_W-1:0]       predicted_r, predicted_s;
  logic signed [SUM_W-1:0]  best_r, best_s;
  logic signed [SUM_W-1:0]  run_max_r, run_max_s;
  logic [CLASS_W-1:0]       run_class_r, run_class_s;
  logic signed [SUM_W-1:0]  cap_sum_r, cap_sum_s;

`ifdef ARGMAX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]         wait_cnt_r, wait_cnt_s;
  logic                     timeout_err_r, timeout_err_s;
`endif

  // Next-state and next-register values; sum_req and busy look ahead so they align with the state
  always_comb begin
    state_s     = state_r;
    class_sel_s = class_sel_r;
    predicted_s = predicted_r;
    best_s      = best_r;
    run_max_s   = run_max_r;
    run_class_s = run_class_r;
    cap_sum_s   = cap_sum_r;
    done_s      = 1'b0;
`ifdef ARGMAX_TIMEOUT_EN
    wait_cnt_s    = wait_cnt_r;
    timeout_err_s = timeout_err_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s     = ST_ISSUE;
          class_sel_s = CLASS_ZERO;
          run_max_s   = MOST_NEG;
          run_class_s = CLASS_ZERO;
`ifdef ARGMAX_TIMEOUT_EN
          timeout_err_s = 1'b0;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_WAIT;
`ifdef ARGMAX_TIMEOUT_EN
        wait_cnt_s = CNT_ZERO;
`endif
      end
      ST_WAIT: begin
        if (bus.sum_valid) begin
          cap_sum_s = bus.class_sum;
          state_s   = ST_COMPARE;
`ifdef ARGMAX_TIMEOUT_EN
        end else if (wait_cnt_r == CNT_LAST) begin
          // A missing sum is scored as the most negative value so it cannot win after class 0
          cap_sum_s     = MOST_NEG;
          timeout_err_s = 1'b1;
          state_s       = ST_COMPARE;
        end else begin
          wait_cnt_s = wait_cnt_r + CNT_ONE;
          state_s    = ST_WAIT;
        end
`else
        end else begin
          state_s = ST_WAIT;
        end
`endif
      end
      ST_COMPARE: begin
        if (take_new(cap_sum_r, run_max_r, class_sel_r)) begin
          run_max_s   = cap_sum_r;
          run_class_s = class_sel_r;
        end else begin
          run_max_s   = run_max_r;
          run_class_s = run_class_r;
        end
        if (class_sel_r == LAST_CLASS) begin
          state_s = ST_DONE;
        end else begin
          class_sel_s = class_sel_r + CLASS_ONE;
          state_s     = ST_ISSUE;
        end
      end
      ST_DONE: begin
        predicted_s = run_class_r;
        best_s      = run_max_r;
        done_s      = 1'b1;
        state_s     = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    sum_req_s = (state_s == ST_ISSUE);
    busy_s    = (state_s != ST_IDLE);
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      class_sel_r <= CLASS_ZERO;
      sum_req_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      predicted_r <= CLASS_ZERO;
      best_r      <= SUM_ZERO;
      run_max_r   <= MOST_NEG;
      run_class_r <= CLASS_ZERO;
      cap_sum_r   <= SUM_ZERO;
    end else begin
      class_sel_r <= class_sel_s;
      sum_req_r   <= sum_req_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      predicted_r <= predicted_s;
      best_r      <= best_s;
      run_max_r   <= run_max_s;
      run_class_r <= run_class_s;
      cap_sum_r   <= cap_sum_s;
    end
  end

`ifdef ARGMAX_TIMEOUT_EN
  // WAIT watchdog counter and sticky error flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_r    <= CNT_ZERO;
      timeout_err_r <= 1'b0;
    end else begin
      wait_cnt_r    <= wait_cnt_s;
      timeout_err_r <= timeout_err_s;
    end
  end

  assign bus.timeout_err = timeout_err_r;
`endif

  assign bus.busy            = busy_r;
  assign bus.class_sel       = class_sel_r;
  assign bus.sum_req         = sum_req_r;
  assign bus.done            = done_r;
  assign bus.predicted_class = predicted_r;
  assign bus.best_sum        = best_r;

endmodule
